// File: rtl/bus_pkg.sv
// bus_pkg: shared encodings and constants for the rq/ack bus server blocks.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } bus_state_e;

  localparam int CNT_W  = 16;
  localparam int LFSR_W = 5;
  // Wide enough for WAIT_CYCLES (<=15) plus up to 3 random extra cycles
  localparam int WAIT_W = 5;
  localparam int ERR_W  = 64;
  localparam logic [ERR_W-1:0] BUS_ERR_DATA = {ERR_W{1'b1}};

endpackage

// File: rtl/wait_lfsr.sv
// wait_lfsr: 5-bit Fibonacci LFSR (taps 5,3) stepping once per enable;
// the low two bits supply the random extra wait of the server.
module wait_lfsr
  import bus_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 5'b00001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [1:0] rnd
);

  logic [LFSR_W-1:0] lfsr;

  always_ff @(posedge clk) begin
    if (!reset)  lfsr <= SEED;
    else if (en) lfsr <= {lfsr[LFSR_W-2:0], lfsr[4] ^ lfsr[2]};
  end

  assign rnd = lfsr[1:0];

endmodule

// File: rtl/reg_server.sv
// reg_server: rq/ack responder backed by a register file, with wait states, out-of-range
// error and traffic counters. Random extra waits enabled by BUS_SERVER_RAND_WAIT_EN.
module reg_server
  import bus_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 8,
  parameter int                    ADDR_WIDTH   = 4,
  parameter int                    MEMORY_DEPTH = 16,
  parameter int                    WAIT_CYCLES  = 0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [LFSR_W-1:0]     LFSR_SEED    = 5'b00001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  rq,
  output logic                  ack,
  input  logic                  wr_ni,
  input  logic [DATA_WIDTH-1:0] dataW,
  output logic [DATA_WIDTH-1:0] dataR,
  output logic                  err,
  output logic [CNT_W-1:0]      wr_count,
  output logic [CNT_W-1:0]      rd_count
);

  localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

  if (LFSR_SEED == '0) begin : g_seed_chk
    $error("reg_server: LFSR_SEED must be non-zero");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_chk
    $error("reg_server: WAIT_CYCLES out of range 0..15");
  end

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  bus_state_e            state, nstate;
  req_t                  req_q, cur;
  logic [WAIT_W-1:0]     cnt, total_wait;
  logic                  cap, go_ack, in_range;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

`ifdef BUS_SERVER_RAND_WAIT_EN
  logic [1:0] rnd;

  // Extra wait uses the LFSR value present at capture; the LFSR then steps.
  wait_lfsr #(.SEED(LFSR_SEED)) u_wait_lfsr (
    .clk   (clk),
    .reset (reset),
    .en    (cap),
    .rnd   (rnd)
  );
  assign total_wait = WAIT_W'(WAIT_CYCLES) + {3'b000, rnd};
`else
  assign total_wait = WAIT_W'(WAIT_CYCLES);
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (rq) nstate = (total_wait == '0) ? ACK : WAIT;
      WAIT:    if (cnt == WAIT_W'(1)) nstate = ACK;
      ACK:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // With zero wait the transaction completes on its capture edge, so the
  // live inputs stand in for the not-yet-latched copy.
  always_comb begin
    cap      = (state == IDLE) && rq;
    cur      = (state == IDLE) ? {address, wr_ni, dataW} : req_q;
    go_ack   = (nstate == ACK);
    in_range = 32'(cur.addr) < MEMORY_DEPTH;
    idx      = IDX_W'(cur.addr);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_q    <= '0;
      cnt      <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      dataR    <= '0;
      wr_count <= '0;
      rd_count <= '0;
      for (int i = 0; i < MEMORY_DEPTH; i++) mem[i] <= RESET_VALUE;
    end else begin
      ack <= go_ack;
      err <= go_ack && !in_range;
      if (cap) begin
        req_q <= cur;
        cnt   <= total_wait;
      end else if (state == WAIT) begin
        cnt <= cnt - WAIT_W'(1);
      end
      if (go_ack) begin
        if (cur.wr) begin
          wr_count <= wr_count + CNT_W'(1);
          if (in_range) mem[idx] <= cur.data;
        end else begin
          rd_count <= rd_count + CNT_W'(1);
          dataR    <= in_range ? mem[idx] : BUS_ERR_DATA[DATA_WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_server.sv
// tb_reg_server: directed and random rq/ack traffic against reg_server, checked every
// cycle by a transaction-level model (edge-indexed completion times, plain arrays).
module tb_reg_server;

  localparam int            DW    = 8;
  localparam int            AW    = 4;
  localparam int            DEPTH = 12;
  localparam int            WC    = 2;
  localparam logic [DW-1:0] RV    = 8'h3C;
`ifdef BUS_SERVER_RAND_WAIT_EN
  // seed 1 gives extras 1,2,0,1,2,1,3,2 for the first captures
  localparam int LAT0 = WC + 1;
  localparam int LAT1 = WC + 2;
`else
  localparam int LAT0 = WC;
  localparam int LAT1 = WC;
`endif

  logic          clk     = 1'b0;
  logic          reset   = 1'b0;
  logic          rq      = 1'b0;
  logic          wr_ni   = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] dataW   = '0;
  logic          ack, err;
  logic [DW-1:0] dataR;
  logic [15:0]   wr_count, rd_count;

  int checks = 0;
  int errors = 0;

  reg_server #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .MEMORY_DEPTH (DEPTH),
    .WAIT_CYCLES  (WC),
    .RESET_VALUE  (RV),
    .LFSR_SEED    (5'b00001)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .rq       (rq),
    .ack      (ack),
    .wr_ni    (wr_ni),
    .dataW    (dataW),
    .dataR    (dataR),
    .err      (err),
    .wr_count (wr_count),
    .rd_count (rd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DW-1:0] mmem [DEPTH];
  bit            armed = 0, busy = 0, m_ack = 0, m_err = 0;
  logic [DW-1:0] m_dataR = '0;
  int            m_wr = 0, m_rd = 0, m_extra = 0;
  longint        cyc = 0, ack_at = 0;
  logic [AW-1:0] r_addr = '0;
  bit            r_wr = 0;
  logic [DW-1:0] r_data = '0;
  logic [4:0]    m_lfsr = 5'b00001;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mmem[i] = RV;
      m_ack = 0; m_err = 0; m_dataR = '0; m_wr = 0; m_rd = 0;
      busy = 0; m_lfsr = 5'b00001; armed = 1;
    end else if (m_ack) begin
      m_ack = 0; m_err = 0; busy = 0;
    end else begin
      if (!busy && rq) begin
        m_extra = 0;
`ifdef BUS_SERVER_RAND_WAIT_EN
        m_extra = int'(m_lfsr[1:0]);
        m_lfsr  = {m_lfsr[3:0], m_lfsr[4] ^ m_lfsr[2]};
`endif
        r_addr = address; r_wr = wr_ni; r_data = dataW;
        ack_at = cyc + WC + m_extra;
        busy   = 1;
      end
      if (busy && cyc == ack_at) begin
        m_ack = 1;
        m_err = int'(r_addr) >= DEPTH;
        if (r_wr) begin
          m_wr = (m_wr + 1) % 65536;
          if (!m_err) mmem[int'(r_addr)] = r_data;
        end else begin
          m_rd    = (m_rd + 1) % 65536;
          m_dataR = m_err ? '1 : mmem[int'(r_addr)];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("ack",      32'(ack),      32'(m_ack));
      chk("err",      32'(err),      32'(m_err));
      chk("dataR",    32'(dataR),    32'(m_dataR));
      chk("wr_count", 32'(wr_count), 32'(16'(m_wr)));
      chk("rd_count", 32'(rd_count), 32'(16'(m_rd)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input logic [AW-1:0] a, input bit w, input logic [DW-1:0] d,
                     input bit early_drop, output logic [DW-1:0] rd, output bit e,
                     output int lat);
    int n;
    n = 0; lat = -1; rd = '0; e = 0;
    address = a; wr_ni = w; dataW = d; rq = 1'b1;
    while (n < 60 && lat < 0) begin
      @(negedge clk);
      n++;
      if (ack) begin
        rd = dataR; e = err; lat = n - 1;
      end else if (early_drop && n == 1) begin
        rq = 1'b0; address = ~a;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL txn_timeout: no ack for addr %0d within 60 cycles", a);
    end
    rq = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] rd;
    bit            e;
    int            lat;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    chk("reset_ack",      32'(ack),      0);
    chk("reset_dataR",    32'(dataR),    0);
    chk("reset_wr_count", 32'(wr_count), 0);
    chk("reset_rd_count", 32'(rd_count), 0);

    txn(4'd3, 1, 8'hA5, 0, rd, e, lat);
    chk("wr3_lat", lat, LAT0);
    chk("wr3_err", 32'(e), 0);
    txn(4'd3, 0, 8'h00, 0, rd, e, lat);
    chk("rd3_lat",  lat, LAT1);
    chk("rd3_data", 32'(rd), 32'h A5);
    chk("rd3_err",  32'(e), 0);
    chk("cnt_wr1",  32'(wr_count), 1);
    chk("cnt_rd1",  32'(rd_count), 1);

    txn(4'd0, 0, 8'h00, 0, rd, e, lat);
    chk("rd0_reset_value", 32'(rd), 32'h3C);

    txn(4'd13, 1, 8'h55, 0, rd, e, lat);
    chk("oor_wr_err", 32'(e), 1);
    txn(4'd13, 0, 8'h00, 0, rd, e, lat);
    chk("oor_rd_err",  32'(e), 1);
    chk("oor_rd_data", 32'(rd), 32'hFF);

    for (int i = 0; i < DEPTH; i++) begin
      txn(AW'(i), 0, 8'h00, 0, rd, e, lat);
      chk("scan_word", 32'(rd), (i == 3) ? 32'hA5 : 32'h3C);
    end
    chk("cnt_wr2",  32'(wr_count), 2);
    chk("cnt_rd15", 32'(rd_count), 15);

    // rq dropped right after capture: latched request must still complete
    txn(4'd5, 1, 8'h81, 1, rd, e, lat);
    chk("early_drop_acked", 32'(lat >= 0), 1);
    txn(4'd5, 0, 8'h00, 0, rd, e, lat);
    chk("early_drop_data", 32'(rd), 32'h81);

    // reset in the middle of a write wait
    txn(4'd2, 1, 8'h99, 0, rd, e, lat);
    address = 4'd2; wr_ni = 1'b1; dataW = 8'h77; rq = 1'b1;
    @(negedge clk);
    chk("midrst_no_ack_yet", 32'(ack), 0);
    reset = 1'b0; rq = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_wr_count", 32'(wr_count), 0);
    chk("midrst_rd_count", 32'(rd_count), 0);
    txn(4'd2, 0, 8'h00, 0, rd, e, lat);
    chk("midrst_addr2", 32'(rd), 32'h3C);
    chk("midrst_lat",   lat, LAT0);

    // random traffic: idle gaps, back-to-back with rq held, out-of-range mixed in
    for (int t = 0; t < 200; t++) begin
      bit got;
      int n;
      got = 0; n = 0;
      address = AW'($urandom_range(0, 15));
      wr_ni   = 1'($urandom_range(0, 1));
      dataW   = DW'($urandom);
      rq      = 1'b1;
      while (!got && n < 60) begin
        @(negedge clk);
        n++;
        got = ack;
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL rand_timeout: no ack in transaction %0d", t);
      end
      if ($urandom_range(0, 2) != 0) begin
        rq = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    rq = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
